// File: rtl/mnist_argmax_if.sv
// Logit-in / result-out bundle for mnist_argmax.
// master: the producer of logit vectors and consumer of results.
// slave:  the argmax block.
interface mnist_argmax_if #(
  parameter int N         = 8,
  parameter int NUM_CLASS = 10,
  parameter int IDX_W     = 4
);
  logic                   logit_vld;
  logic [NUM_CLASS*N-1:0] logit_din;
  logic                   logit_end;
  logic [IDX_W-1:0]       result_idx;
  logic [N-1:0]           result_max;
  logic                   result_end;
  logic                   result_vld;
  logic                   result_rdy;

  modport master (
    output logit_vld, logit_din, logit_end, result_rdy,
    input  result_idx, result_max, result_end, result_vld
  );

  modport slave (
    input  logit_vld, logit_din, logit_end, result_rdy,
    output result_idx, result_max, result_end, result_vld
  );
endinterface

// File: rtl/mnist_argmax.sv
// mnist_argmax: sequential argmax over a vector of NUM_CLASS signed logits,
// one compare per enabled cycle, result returned over a valid/ready port.
// Optional build macro MNIST_ARGMAX_TIE_HIGH_EN: ties resolve to the highest
// index (>=) instead of the lowest (>).
//
// Handshake: logit_vld is a one-cycle strobe with no backpressure; a vector
// is taken in IDLE, or in DONE on the same cycle the pending result is
// consumed; otherwise it is dropped and overrun sticks high. result_vld is
// held with stable idx/max/end until a cycle with ce && result_rdy, which
// consumes the result. ce low freezes everything, including handshakes.
module mnist_argmax #(
  parameter int N         = 8,
  parameter int NUM_CLASS = 10,
  parameter int IDX_W     = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ce,
  mnist_argmax_if.slave      bus,
  output logic               busy,
  output logic               overrun,
  output logic [1:0]         state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASS - 1);

  state_t                 state;
  logic [NUM_CLASS*N-1:0] vec_q;
  logic                   end_q;
  logic [IDX_W-1:0]       cnt;
  logic [IDX_W-1:0]       best_idx;
  logic signed [N-1:0]    best_val;
  logic signed [N-1:0]    cur_val;
  logic                   take;
  logic                   accept;

  logic [IDX_W-1:0]       res_idx_q;
  logic [N-1:0]           res_max_q;
  logic                   res_end_q;
  logic                   res_vld_q;

  assign bus.result_idx = res_idx_q;
  assign bus.result_max = res_max_q;
  assign bus.result_end = res_end_q;
  assign bus.result_vld = res_vld_q;
  assign state_dbg      = state;

  // Select the logit currently under comparison.
  always_comb begin
    cur_val = '0;
    for (int k = 0; k < NUM_CLASS; k++) begin
      if (int'(cnt) == k) cur_val = vec_q[k*N +: N];
    end
  end

`ifdef MNIST_ARGMAX_TIE_HIGH_EN
  assign take = (cur_val >= best_val);
`else
  assign take = (cur_val > best_val);
`endif

  // A new vector enters SCAN from IDLE, or from DONE when the result leaves.
  assign accept = ce && bus.logit_vld &&
                  ((state == IDLE) || ((state == DONE) && bus.result_rdy));

  // Scan FSM with registered outputs; accept overrides the DONE exit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      vec_q     <= '0;
      end_q     <= 1'b0;
      cnt       <= '0;
      best_idx  <= '0;
      best_val  <= '0;
      res_idx_q <= '0;
      res_max_q <= '0;
      res_end_q <= 1'b0;
      res_vld_q <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else if (ce) begin
      case (state)
        IDLE: ;
        SCAN: begin
          if (bus.logit_vld) overrun <= 1'b1;
          if (take) begin
            best_idx <= cnt;
            best_val <= cur_val;
          end
          if (cnt == LAST_IDX) begin
            state     <= DONE;
            res_vld_q <= 1'b1;
            res_idx_q <= take ? cnt : best_idx;
            res_max_q <= take ? cur_val : best_val;
            res_end_q <= end_q;
          end else begin
            cnt <= cnt + IDX_W'(1);
          end
        end
        DONE: begin
          if (bus.result_rdy) begin
            res_vld_q <= 1'b0;
            state     <= IDLE;
            busy      <= 1'b0;
          end else if (bus.logit_vld) begin
            overrun <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase

      if (accept) begin
        vec_q    <= bus.logit_din;
        end_q    <= bus.logit_end;
        best_idx <= '0;
        best_val <= bus.logit_din[N-1:0];
        cnt      <= IDX_W'(1);
        state    <= SCAN;
        busy     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mnist_argmax.sv
// Self-checking bench for mnist_argmax.
module tb_mnist_argmax;

  localparam int N         = 8;
  localparam int NUM_CLASS = 10;
  localparam int IDX_W     = 4;
  localparam int VW        = NUM_CLASS * N;
  localparam int W         = 1 + IDX_W + N;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ce = 1'b1;
  logic busy, overrun;
  logic [1:0] state_dbg;

  always #5 clk = ~clk;

  mnist_argmax_if #(.N(N), .NUM_CLASS(NUM_CLASS), .IDX_W(IDX_W)) bus ();

  mnist_argmax #(.N(N), .NUM_CLASS(NUM_CLASS), .IDX_W(IDX_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ce       (ce),
    .bus      (bus),
    .busy     (busy),
    .overrun  (overrun),
    .state_dbg(state_dbg)
  );

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  int vals_a[10] = '{-5, 3, 12, 7, -128, 0, 11, 12, -1, 2};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference argmax over a packed vector.
  function automatic logic [W-1:0] model(input logic [VW-1:0] v, input logic e);
    int bi, bv, x;
    bi = 0;
    bv = $signed(v[N-1:0]);
    for (int k = 1; k < NUM_CLASS; k++) begin
      x = $signed(v[k*N +: N]);
`ifdef MNIST_ARGMAX_TIE_HIGH_EN
      if (x >= bv) begin bi = k; bv = x; end
`else
      if (x > bv) begin bi = k; bv = x; end
`endif
    end
    return {e, bi[IDX_W-1:0], bv[N-1:0]};
  endfunction

  function automatic logic [VW-1:0] fill(input int v);
    logic [VW-1:0] r;
    for (int k = 0; k < NUM_CLASS; k++) r[k*N +: N] = v[N-1:0];
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Present one vector for a single cycle; returns just after that edge.
  task automatic send(input logic [VW-1:0] v, input logic e);
    bus.logit_din = v;
    bus.logit_end = e;
    bus.logit_vld = 1'b1;
    cyc();
    bus.logit_vld = 1'b0;
  endtask

  task automatic wait_lat(input string tag, input int exp_n);
    int n = 0;
    while (!bus.result_vld && n < 100) begin
      cyc();
      n++;
    end
    check(tag, n, exp_n);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n && ce && bus.result_vld && bus.result_rdy) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_result", 32'd1, 32'd0);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("sb_result", {19'd0, bus.result_end, bus.result_idx, bus.result_max}, {19'd0, e});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [VW-1:0] v;
    logic e;
    int n;

    bus.logit_vld  = 1'b0;
    bus.logit_din  = '0;
    bus.logit_end  = 1'b0;
    bus.result_rdy = 1'b1;

    // Reset state
    repeat (3) cyc();
    check("rst_vld", bus.result_vld, 0);
    check("rst_idx", bus.result_idx, 0);
    check("rst_max", bus.result_max, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_state", state_dbg, 0);
    rst_n = 1'b1;
    cyc();

    // Mixed logits with a tie at 12
    for (int k = 0; k < NUM_CLASS; k++) v[k*N +: N] = vals_a[k][N-1:0];
`ifdef MNIST_ARGMAX_TIE_HIGH_EN
    exp_q.push_back({1'b0, 4'd7, 8'd12});
`else
    exp_q.push_back({1'b0, 4'd2, 8'd12});
`endif
    send(v, 1'b0);
    check("a_busy", busy, 1);
    check("a_state_scan", state_dbg, 1);
    wait_lat("a_latency", 9);
    cyc();

    // All -128
`ifdef MNIST_ARGMAX_TIE_HIGH_EN
    exp_q.push_back({1'b0, 4'd9, 8'h80});
`else
    exp_q.push_back({1'b0, 4'd0, 8'h80});
`endif
    send(fill(-128), 1'b0);
    wait_lat("b_latency", 9);
    cyc();

    // All 127 except class 9 = -1
    v = fill(127);
    v[9*N +: N] = 8'hFF;
`ifdef MNIST_ARGMAX_TIE_HIGH_EN
    exp_q.push_back({1'b0, 4'd8, 8'h7F});
`else
    exp_q.push_back({1'b0, 4'd0, 8'h7F});
`endif
    send(v, 1'b0);
    wait_lat("c_latency", 9);

    // Random vectors back-to-back at the minimum period
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < NUM_CLASS; k++) v[k*N +: N] = 8'($urandom_range(0, 255));
      if (r == 2) v[4*N +: N] = v[1*N +: N];
      e = 1'($urandom_range(0, 1));
      exp_q.push_back(model(v, e));
      send(v, e);
      wait_lat("rand_latency", 9);
    end
    cyc();
    check("rand_no_overrun", overrun, 0);

    // ce toggling during SCAN, with a logit_vld pulse in a ce=0 cycle
    v = fill(-3);
    v[8*N +: N] = 8'd20;
    exp_q.push_back({1'b0, 4'd8, 8'd20});
    send(v, 1'b0);
    ce = 1'b0;
    n = 0;
    while (n < 100) begin
      cyc();
      n++;
      if (bus.result_vld) break;
      ce = ~ce;
      bus.logit_vld = (n == 4);
      bus.logit_din = fill(50);
    end
    bus.logit_vld = 1'b0;
    ce = 1'b1;
    check("ce_latency", n, 18);
    check("ce_no_overrun", overrun, 0);
    cyc();

    // Backpressure: hold result 20 cycles, drop a vector mid-wait
    bus.result_rdy = 1'b0;
    v = fill(0);
    v[3*N +: N] = 8'd50;
    exp_q.push_back({1'b0, 4'd3, 8'd50});
    send(v, 1'b0);
    wait_lat("bp_latency", 9);
    for (int i = 0; i < 20; i++) begin
      bus.logit_vld = (i == 4);
      bus.logit_din = fill(99);
      cyc();
      if (i == 10) check("bp_hold_vld", bus.result_vld, 1);
    end
    bus.logit_vld = 1'b0;
    check("bp_overrun", overrun, 1);
    check("bp_busy", busy, 1);
    check("bp_vld", bus.result_vld, 1);
    check("bp_idx", bus.result_idx, 3);
    check("bp_max", bus.result_max, 50);
    bus.result_rdy = 1'b1;
    v = fill(1);
    v[7*N +: N] = 8'd90;
    exp_q.push_back({1'b0, 4'd7, 8'd90});
    send(v, 1'b0);
    check("bp_direct_scan", state_dbg, 1);
    check("bp_vld_low", bus.result_vld, 0);
    wait_lat("bp_third_latency", 9);
    cyc();

    // Reset 4 cycles into SCAN
    send(fill(5), 1'b1);
    repeat (4) cyc();
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_vld", bus.result_vld, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_overrun", overrun, 0);
    check("mid_rst_idx", bus.result_idx, 0);
    check("mid_rst_max", bus.result_max, 0);
    check("mid_rst_state", state_dbg, 0);
    cyc();
    #2;
    rst_n = 1'b1;
    cyc();
    v = fill(0);
    v[5*N +: N] = 8'd100;
    exp_q.push_back({1'b0, 4'd5, 8'd100});
    send(v, 1'b0);
    wait_lat("post_rst_latency", 9);
    cyc();
    check("post_rst_overrun", overrun, 0);

    // logit_end propagation, back-to-back
    v = fill(-10);
    v[6*N +: N] = 8'd33;
    exp_q.push_back({1'b1, 4'd6, 8'd33});
    send(v, 1'b1);
    wait_lat("end1_latency", 9);
    check("end1_flag", bus.result_end, 1);
    v = fill(-10);
    v[1*N +: N] = 8'd44;
    exp_q.push_back({1'b0, 4'd1, 8'd44});
    send(v, 1'b0);
    wait_lat("end0_latency", 9);
    check("end0_flag", bus.result_end, 0);
    repeat (3) cyc();

    check("sb_drained", exp_q.size(), 0);
    check("final_idle", state_dbg, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mnist_argmax.md
# mnist_argmax

Classification back-end for the MNIST depthwise-separable CNN pipeline. It consumes the final-layer logit vector stream (`conv_dout` / `conv_dout_vld` / `conv_dout_end` of the network top) and scans the `NUM_CLASS` signed logits sequentially, one comparison per cycle. It returns the winning class index and its logit through a valid/ready result port. It sits between the network top and the host-side result register or UART.

## Interface
- `N`, 8, logit width in bits, two's complement.
- `NUM_CLASS`, 10, number of logits per vector.
- `IDX_W`, 4, class index width; must satisfy 2^IDX_W >= NUM_CLASS.

Ports (one clock; reset is asynchronous and active-low):
- `clk` input 1 system clock; all state on the rising edge.
- `rst_n` input 1 asynchronous active-low reset.
- `ce` input 1 clock enable; gates every state update.
- `logit_vld` input 1 logit vector valid, one-cycle strobe, no backpressure.
- `logit_din` input NUM_CLASS*N logits; class k at bits [k*N +: N].
- `logit_end` input 1 frame-end marker qualified by `logit_vld`.
- `result_idx` output IDX_W winning class index.
- `result_max` output N winning logit value.
- `result_end` output 1 copy of `logit_end` latched with the vector.
- `result_vld` output 1 result valid; held until accepted.
- `result_rdy` input 1 downstream ready.
- `busy` output 1 high in SCAN or DONE.
- `overrun` output 1 sticky: a vector was dropped; cleared only by reset.

## Operation
- States: IDLE, SCAN, DONE. On reset: IDLE; all outputs 0; internal vector register, counter and best registers 0.
- Vector acceptance:
  - Accepted when `ce && logit_vld` in IDLE, or in DONE in the same cycle as `result_vld && result_rdy` (back-to-back).
  - On acceptance: latch `logit_din` and `logit_end`, set best_idx=0, best_val=class 0, cnt=1, go to SCAN.
- SCAN, each `ce` cycle:
  - Compare class cnt against best_val as signed N-bit values.
  - If strictly greater, replace best_idx/best_val.
  - cnt++. After cnt = NUM_CLASS-1 is compared, go to DONE.
- DONE:
  - `result_vld`=1, and `result_idx`/`result_max`/`result_end` are stable.
  - On `ce && result_rdy`: the result is consumed; go to IDLE, or to SCAN if a new vector is accepted in the same cycle.
- Drop rule: `ce && logit_vld` in SCAN, or in DONE without a completing handshake, drops the vector and sets `overrun`=1. State is unaffected.
- Tie rule: equal logits keep the earlier (lower) index unless the configuration macro below is defined.
- `ce`=0 freezes state, counter and outputs; `logit_vld` is ignored, and a handshake does not complete.
- `rst_n` deasserted mid-scan or in DONE: immediate return to IDLE. The pending result is lost and `result_vld` drops asynchronously.

## Timing
- Vector accepted at edge T with `ce` held high:
  - Compares occur at edges T+1 .. T+NUM_CLASS-1.
  - `result_vld` rises after edge T+NUM_CLASS-1 (9 cycles after acceptance for the defaults).
- Minimum vector period with `result_rdy` tied high: NUM_CLASS cycles. Vectors arriving faster set `overrun`.
- `ce` low cycles extend the latency one-for-one.
- Outputs are registered; there is no combinational path from `logit_din` or `result_rdy` to any output.
- `busy` = (state != IDLE), registered.

## Configuration
- `MNIST_ARGMAX_TIE_HIGH_EN`:
  - Defined: the comparison is greater-or-equal, so ties resolve to the highest index.
  - Undefined (default): the comparison is strictly-greater, so ties resolve to the lowest index.

## Test plan
- Logits {-5,3,12,7,-128,0,11,12,-1,2} (class 0..9), `result_rdy`=1 -> `result_vld` 9 cycles after acceptance; idx=2, max=12 (idx=7 with `MNIST_ARGMAX_TIE_HIGH_EN`).
- All logits -128 -> idx=0, max=0x80 (idx=9 with the macro). All logits 127 except class 9=-1 -> idx=0, max=0x7F.
- `result_rdy`=0 for 20 cycles after `result_vld` -> outputs held, `busy`=1. A second `logit_vld` at cycle 5 of the wait -> `overrun`=1, first result unchanged. Raise `result_rdy` together with a third vector -> third vector enters SCAN directly, `result_vld` low for 9 cycles.
- `ce` toggled 1/0 every cycle during SCAN -> result appears after 18 cycles with correct idx; `logit_vld` pulsed during a `ce`=0 cycle -> ignored, no overrun.
- `rst_n` asserted 4 cycles into SCAN -> all outputs 0 immediately. After release, a vector with class 5=100 and all others 0 -> idx=5, max=100, `overrun`=0.
- `logit_end`=1 with the vector -> `result_end`=1 with `result_vld`. Next vector with `logit_end`=0 -> `result_end`=0.
